// File: rtl/alu_disp_pkg.sv
// -----------------------------------------------------------------------------
// alu_disp_pkg
// Shared constants for the ALU result display: active-high 7-segment patterns
// for hex digits 0-F, the dash and blank patterns, and the digit slot indices
// used by the scan logic.
// Bit order of every pattern is {g,f,e,d,c,b,a}, bit 0 = segment a.
// -----------------------------------------------------------------------------
package alu_disp_pkg;

   // Entry n is the active-high pattern for hex digit n (index 15 listed first).
   localparam logic [15:0][6:0] SEG_HEX = {
      7'h71,  // F
      7'h79,  // E
      7'h5E,  // d
      7'h39,  // C
      7'h7C,  // b
      7'h77,  // A
      7'h6F,  // 9
      7'h7F,  // 8
      7'h07,  // 7
      7'h7D,  // 6
      7'h6D,  // 5
      7'h66,  // 4
      7'h4F,  // 3
      7'h5B,  // 2
      7'h06,  // 1
      7'h3F   // 0
   };

   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [1:0] DIG_RES_LO = 2'd0;
   localparam logic [1:0] DIG_RES_HI = 2'd1;
   localparam logic [1:0] DIG_CARRY  = 2'd2;
   localparam logic [1:0] DIG_OP     = 2'd3;

endpackage

// File: rtl/hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
// Combinational nibble to 7-segment decoder, active-high output. Polarity for
// the board is applied by the instantiating module.
// Ports:
//   nibble  in  4  hex value 0-F
//   seg     out 7  active-high pattern {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module hex_to_seg7
   import alu_disp_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_HEX[nibble];
   end

endmodule

// File: rtl/alu_result_display.sv
// -----------------------------------------------------------------------------
// alu_result_display
// Captures the ALU result, carry flag and opcode on a load strobe, holds them,
// and scans them onto a 4-digit time-multiplexed 7-segment display:
//   digit3 = opcode (with decimal point as separator), digit2 = carry,
//   digit1 = result high nibble, digit0 = result low nibble.
// Until the first capture after reset every digit shows a dash.
//
// Parameters:
//   SCAN_DIV        clk cycles per digit slot (2 .. 2^20)
//   SEG_ACTIVE_LOW  1 = seg/dp active-low, 0 = active-high
//   AN_ACTIVE_LOW   1 = an active-low, 0 = active-high
// Ports:
//   clk        in  1  system clock, posedge
//   reset      in  1  synchronous active-high reset
//   load       in  1  capture strobe
//   alu_out    in  8  ALU result
//   carry_out  in  1  ALU carry flag
//   alu_sel    in  4  ALU opcode
//   ack        out 1  one-cycle pulse after each capture
//   seg        out 7  segments {g,f,e,d,c,b,a}
//   dp         out 1  decimal point
//   an         out 4  digit enables, an[0] = digit0
// Build option:
//   ALU_DISP_LZ_BLANK_EN  blank digit1 when the result high nibble is zero
// -----------------------------------------------------------------------------
module alu_result_display
   import alu_disp_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] alu_out,
   input  logic       carry_out,
   input  logic [3:0] alu_sel,
   output logic       ack,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an
);

   localparam int               PRE_W    = $clog2(SCAN_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

   localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);
   localparam logic [3:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

   logic [7:0]       result_q, result_d;
   logic             carry_q, carry_d;
   logic [3:0]       sel_q, sel_d;
   logic             valid_q, valid_d;
   logic             ack_q, ack_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [1:0]       digit_idx_q, digit_idx_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic [3:0]       an_q, an_d;

   logic             tick;
   logic [3:0]       nibble;
   logic [6:0]       hex_pat;
   logic [6:0]       pat;
   logic             dp_on;
   logic [3:0]       an_onehot;

   // ---- capture, prescaler and digit scan ----
   always_comb begin
      result_d    = result_q;
      carry_d     = carry_q;
      sel_d       = sel_q;
      valid_d     = valid_q;
      ack_d       = load;
      if (load) begin
         result_d = alu_out;
         carry_d  = carry_out;
         sel_d    = alu_sel;
         valid_d  = 1'b1;
      end

      tick        = (pre_q == PRE_LAST);
      pre_d       = tick ? '0 : pre_q + PRE_W'(1);
      // Two-bit index wraps 3 -> 0 naturally.
      digit_idx_d = tick ? digit_idx_q + 2'd1 : digit_idx_q;
   end

   always_comb begin
      nibble = result_q[3:0];
      case (digit_idx_q)
         DIG_RES_LO: nibble = result_q[3:0];
         DIG_RES_HI: nibble = result_q[7:4];
         DIG_CARRY:  nibble = {3'b000, carry_q};
         DIG_OP:     nibble = sel_q;
         default:    nibble = result_q[3:0];
      endcase
   end

   hex_to_seg7 u_hex_to_seg7 (
      .nibble (nibble),
      .seg    (hex_pat)
   );

   // ---- output register stage: pattern select and board polarity ----
   always_comb begin
      pat = valid_q ? hex_pat : SEG_DASH;
`ifdef ALU_DISP_LZ_BLANK_EN
      if (valid_q && (digit_idx_q == DIG_RES_HI) && (result_q[7:4] == 4'h0)) begin
         pat = SEG_BLANK;
      end
`endif
      dp_on     = valid_q && (digit_idx_q == DIG_OP);
      an_onehot = 4'b0001 << digit_idx_q;

      seg_d = (SEG_ACTIVE_LOW != 0) ? ~pat : pat;
      dp_d  = (SEG_ACTIVE_LOW != 0) ? ~dp_on : dp_on;
      an_d  = (AN_ACTIVE_LOW != 0) ? ~an_onehot : an_onehot;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result_q    <= '0;
         carry_q     <= 1'b0;
         sel_q       <= '0;
         valid_q     <= 1'b0;
         ack_q       <= 1'b0;
         pre_q       <= '0;
         digit_idx_q <= '0;
         seg_q       <= SEG_OFF;
         dp_q        <= DP_OFF;
         an_q        <= AN_OFF;
      end else begin
         result_q    <= result_d;
         carry_q     <= carry_d;
         sel_q       <= sel_d;
         valid_q     <= valid_d;
         ack_q       <= ack_d;
         pre_q       <= pre_d;
         digit_idx_q <= digit_idx_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         an_q        <= an_d;
      end
   end

   assign ack = ack_q;
   assign seg = seg_q;
   assign dp  = dp_q;
   assign an  = an_q;

endmodule
